// File: rtl/netflow_record_collector_if.sv
// Export-stream slave plus record output port of the flow collector.
// slave is the collector's view, master the producer/consumer side.
interface netflow_record_collector_if #(
  parameter int DW = 64
);
  logic [DW-1:0]   S_AXIS_TDATA;
  logic [DW/8-1:0] S_AXIS_TSTRB;
  logic            S_AXIS_TLAST;
  logic            S_AXIS_TVALID;
  logic            S_AXIS_TREADY;
  logic [239:0]    rec_data;
  logic            rec_valid;
  logic            rec_ready;

  modport slave (
    input  S_AXIS_TDATA, S_AXIS_TSTRB,
    input  S_AXIS_TLAST, S_AXIS_TVALID,
    input  rec_ready,
    output S_AXIS_TREADY,
    output rec_data, rec_valid
  );

  modport master (
    output S_AXIS_TDATA, S_AXIS_TSTRB,
    output S_AXIS_TLAST, S_AXIS_TVALID,
    output rec_ready,
    input  S_AXIS_TREADY,
    input  rec_data, rec_valid
  );
endinterface

// File: rtl/netflow_record_collector.sv
// Flow-export receiver: validates frame framing and reassembles
// 240-bit flow records from 4-beat groups on a 64-bit stream.
module netflow_record_collector #(
  parameter int unsigned MAX_RECORDS = 30,
  parameter int C_S_AXIS_DATA_WIDTH = 64
) (
  input  logic        ACLK,
  input  logic        ARESET,
  netflow_record_collector_if.slave s_axis,
  output logic [31:0] hdr_pkt_count,
  output logic [31:0] hdr_collisions,
  output logic [31:0] frames_ok,
  output logic [31:0] frames_err
);

  localparam int CW = $clog2(MAX_RECORDS + 1);

  typedef enum logic [1:0] {
    HDR0, HDR1, REC, DROP
  } state_t;

  state_t state, state_nx;

  logic [C_S_AXIS_DATA_WIDTH-1:0] d;
  logic [7:0]    strb;
  logic          last;
  logic [1:0]    beat;
  logic [CW-1:0] rec_cnt;
  logic [CW-1:0] n_sh;
  logic [31:0]   pkt_sh;
  logic [191:0]  asm_q;
  logic [239:0]  rec_data_q;
  logic          rec_valid_q;
  logic          stall;
  logic          fire;
  logic          last_rec;
  logic          err;
  logic          good_b3;
  logic          commit;
  logic          ok_inc;

  assign d    = s_axis.S_AXIS_TDATA;
  assign strb = s_axis.S_AXIS_TSTRB;
  assign last = s_axis.S_AXIS_TLAST;

  // Only the closing beat of a record waits on the consumer.
  assign stall = (state == REC) && (beat == 2'd3)
              && rec_valid_q && !s_axis.rec_ready;

  assign s_axis.S_AXIS_TREADY = ARESET || !stall;
  assign s_axis.rec_data  = rec_data_q;
  assign s_axis.rec_valid = rec_valid_q;

  assign fire = s_axis.S_AXIS_TVALID
             && s_axis.S_AXIS_TREADY;
  assign last_rec = (rec_cnt == n_sh - CW'(1));

  always_comb begin
    state_nx = state;
    err      = 1'b0;
    good_b3  = 1'b0;
    commit   = 1'b0;
    ok_inc   = 1'b0;
    if (fire) begin
      unique case (state)
        HDR0: begin
          if (last || d[63:32] > 32'(MAX_RECORDS))
            err = 1'b1;
          else
            state_nx = HDR1;
        end
        HDR1: begin
          if (last && n_sh == '0) begin
            commit   = 1'b1;
            ok_inc   = 1'b1;
            state_nx = HDR0;
          end else if (!last && n_sh != '0) begin
            commit   = 1'b1;
            state_nx = REC;
          end else begin
            err = 1'b1;
          end
        end
        REC: begin
          if (strb != ((beat == 2'd3) ? 8'h3F : 8'hFF))
            err = 1'b1;
          else if (beat != 2'd3)
            err = last;
          else if (last != last_rec)
            err = 1'b1;
          else begin
            good_b3 = 1'b1;
            if (last_rec) begin
              ok_inc   = 1'b1;
              state_nx = HDR0;
            end
          end
        end
        DROP: begin
          if (last) state_nx = HDR0;
        end
        default: ;
      endcase
    end
    if (err) state_nx = last ? HDR0 : DROP;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state          <= HDR0;
      beat           <= '0;
      rec_cnt        <= '0;
      n_sh           <= '0;
      pkt_sh         <= '0;
      asm_q          <= '0;
      rec_data_q     <= '0;
      rec_valid_q    <= 1'b0;
      hdr_pkt_count  <= '0;
      hdr_collisions <= '0;
      frames_ok      <= '0;
      frames_err     <= '0;
    end else begin
      state <= state_nx;
      if (fire && state == HDR0) begin
        n_sh   <= d[32 +: CW];
        pkt_sh <= d[31:0];
      end
      if (commit) begin
        hdr_pkt_count  <= pkt_sh;
        hdr_collisions <= d[31:0];
      end
      if (fire && state == REC && !err) begin
        unique case (beat)
          2'd0: asm_q[63:0]    <= d;
          2'd1: asm_q[127:64]  <= d;
          2'd2: asm_q[191:128] <= d;
          default: ;
        endcase
      end
      if (state_nx != REC)
        beat <= '0;
      else if (fire && state == REC)
        beat <= beat + 2'd1;
      if (err || commit)
        rec_cnt <= '0;
      else if (good_b3)
        rec_cnt <= last_rec ? '0 : rec_cnt + CW'(1);
      // Load and drain can coincide, so a new record never bubbles.
      if (good_b3) begin
        rec_data_q  <= {d[47:0], asm_q};
        rec_valid_q <= 1'b1;
      end else if (rec_valid_q && s_axis.rec_ready) begin
        rec_valid_q <= 1'b0;
      end
      if (ok_inc && frames_ok != '1)
        frames_ok <= frames_ok + 32'd1;
      if (err && frames_err != '1)
        frames_err <= frames_err + 32'd1;
    end
  end

endmodule
